// File: rtl/dmem_pkg.sv
// Shared DMCtrl width/sign codes and LSU state type, also used by the control unit.
// The legality helper keeps the misalign/illegal-code rule in one place.
package dmem_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

  // Stores have no zero-extend variants, so BU/HU are illegal when i_wr=1.
  function automatic logic dm_illegal(input logic [2:0] i_ctrl, input logic i_wr,
                                      input logic [1:0] i_addr_lo);
    case (i_ctrl)
      DM_B:    return 1'b0;
      DM_BU:   return i_wr;
      DM_H:    return i_addr_lo[0];
      DM_HU:   return i_wr | i_addr_lo[0];
      DM_W:    return i_addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_format.sv
// Selects the byte or half lane of a RAM word and sign- or zero-extends it
// according to DMCtrl.
module dmem_load_format
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    case (i_ctrl)
      DM_B:    o_data = {{24{w_byte[7]}}, w_byte};
      DM_BU:   o_data = {24'd0, w_byte};
      DM_H:    o_data = {{16{w_half[15]}}, w_half};
      DM_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: single-beat Req/Valid handshake in front of a
// word-organised RAM, with byte/half/word access, optional wait states and error flagging.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  output logic        Busy,
  output logic        Valid,
  output logic [31:0] DataRd,
  output logic        MisalignErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t r_state, w_state_next;

  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_wr;
  logic [2:0]    r_ctrl;
  logic [3:0]    r_cnt;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_rdata;

  logic          w_accept;
  logic          w_err;
  logic          w_do_write;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_data;
  logic [31:0]   w_merged;
  logic [31:0]   w_load;
  logic          w_unused_addr;

  assign w_unused_addr = ^Address[31:AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    Busy         = 1'b0;
    Valid        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Req) begin
          w_accept     = 1'b1;
          w_state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        Busy = 1'b1;
        if (r_cnt <= 4'd1) w_state_next = ACCESS;
      end
      ACCESS: begin
        Busy         = 1'b1;
        w_state_next = RESP;
      end
      RESP: begin
        Valid = 1'b1;
        if (Req) begin
          w_accept     = 1'b1;
          w_state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_ctrl  <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_addr  <= Address[AW+1:0];
      r_wdata <= DataWr;
      r_wr    <= DMWr;
      r_ctrl  <= DMCtrl;
      r_cnt   <= 4'(WAIT_CYCLES);
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // The word is read on the accept edge, so it is ready for the merge or load in ACCESS.
  always_ff @(posedge clk) begin
    if (w_accept)   r_rdata <= r_mem[Address[AW+1:2]];
    if (w_do_write) r_mem[r_addr[AW+1:2]] <= w_merged;
  end

  assign w_err      = dm_illegal(r_ctrl, r_wr, r_addr[1:0]);
  assign w_do_write = (r_state == ACCESS) && r_wr && !w_err;

  always_comb begin
    w_be        = 4'b1111;
    w_lane_data = r_wdata;
    case (r_ctrl)
      DM_B: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_lane_data = {4{r_wdata[7:0]}};
      end
      DM_H: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_lane_data = r_wdata;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_merged[8*gi +: 8] = w_be[gi] ? w_lane_data[8*gi +: 8] : r_rdata[8*gi +: 8];
  end

  dmem_load_format u_fmt (
    .i_word    (r_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_ctrl    (r_ctrl),
    .o_data    (w_load)
  );

  // Store responses leave DataRd untouched so the last load value stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DataRd      <= '0;
      MisalignErr <= 1'b0;
    end else if (r_state == ACCESS) begin
      if (w_err) begin
        DataRd      <= '0;
        MisalignErr <= 1'b1;
      end else begin
        MisalignErr <= 1'b0;
        if (!r_wr) DataRd <= w_load;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a zero-wait and a three-wait instance,
// checked against a byte-addressed reference memory.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk;
  logic        rst    [2];
  logic        req    [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        dmwr   [2];
  logic [2:0]  dmctrl [2];
  logic        busy   [2];
  logic        valid  [2];
  logic [31:0] datard [2];
  logic        merr   [2];

  int errors = 0;
  int checks = 0;

  bit [7:0]  mm [2][1024];
  bit [31:0] lr [2];

  dmem_lsu #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .Req(req[0]), .Address(addr[0]), .DataWr(wdata[0]),
    .DMWr(dmwr[0]), .DMCtrl(dmctrl[0]), .Busy(busy[0]), .Valid(valid[0]),
    .DataRd(datard[0]), .MisalignErr(merr[0])
  );

  dmem_lsu #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst[1]), .Req(req[1]), .Address(addr[1]), .DataWr(wdata[1]),
    .DMWr(dmwr[1]), .DMCtrl(dmctrl[1]), .Busy(busy[1]), .Valid(valid[1]),
    .DataRd(datard[1]), .MisalignErr(merr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: little-endian byte memory aliased to 1 KiB, rules taken straight from DMCtrl.
  function automatic void model(input int d, input bit wr, input bit [2:0] ctrl,
                                input bit [31:0] a, input bit [31:0] data,
                                output bit err, output bit [31:0] rd);
    int size, ba;
    bit uns;
    bit [31:0] v;
    ba = int'(a[9:0]);
    uns = ctrl[2];
    err = 1'b0;
    size = 1;
    case (ctrl)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        err = 1'b1;
    endcase
    if (wr && uns) err = 1'b1;
    if (ba % size != 0) err = 1'b1;
    if (err) begin
      lr[d] = 32'd0;
    end else if (wr) begin
      for (int i = 0; i < size; i++) mm[d][ba+i] = data[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mm[d][ba+i];
      if (!uns && size == 1 && v[7])  v[31:8]  = '1;
      if (!uns && size == 2 && v[15]) v[31:16] = '1;
      lr[d] = v;
    end
    rd = lr[d];
  endfunction

  task automatic xact(input int d, input bit wr, input bit [2:0] ctrl, input bit [31:0] a,
                      input bit [31:0] data, output logic [31:0] rd, output logic err,
                      output int lat, output bit [31:0] exp_rd, output bit exp_err);
    @(negedge clk);
    req[d] = 1'b1; dmwr[d] = wr; dmctrl[d] = ctrl; addr[d] = a; wdata[d] = data;
    @(posedge clk);
    #1 req[d] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (valid[d] === 1'b1) begin
        lat = k;
        break;
      end
    end
    rd  = datard[d];
    err = merr[d];
    model(d, wr, ctrl, a, data, exp_err, exp_rd);
    $display("xact dut%0d wr=%0b ctrl=%0d addr=%h wdata=%h rd=%h err=%0b lat=%0d",
             d, wr, ctrl, a, data, rd, err, lat);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) rst[d] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], valid[d], merr[d]} !== 3'b000 || datard[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: busy=%b valid=%b err=%b rd=%h, required all zero",
                 d, busy[d], valid[d], merr[d], datard[d]);
      end
    end
    for (int d = 0; d < 2; d++) rst[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd; logic err; int lat; bit [31:0] er; bit ee;
    xact(0, 1, DM_W, 32'h10, 32'hDEADBEEF, rd, err, lat, er, ee);
    xact(0, 0, DM_W, 32'h10, 32'h0, rd, err, lat, er, ee);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d required 2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h required deadbeef", rd); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b required 0", err); end
  endtask

  task automatic test_sign();
    logic [31:0] rd; logic err; int lat; bit [31:0] er; bit ee;
    bit [2:0]  ctl [4] = '{DM_B, DM_BU, DM_H, DM_HU};
    bit [31:0] ad  [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    bit [31:0] ex  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    for (int i = 0; i < 4; i++) begin
      xact(0, 0, ctl[i], ad[i], 32'h0, rd, err, lat, er, ee);
      checks++;
      if (rd !== ex[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL sign_load%0d: got %h err=%b required %h err=0", i, rd, err, ex[i]);
      end
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic err; int lat; bit [31:0] er; bit ee;
    xact(0, 1, DM_B, 32'h11, 32'hAAAAAA55, rd, err, lat, er, ee);
    checks++;
    if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL store_keeps_datard: got %h required 0000dead", rd); end
    xact(0, 0, DM_W, 32'h10, 32'h0, rd, err, lat, er, ee);
    checks++;
    if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_lane: got %h required dead55ef", rd); end
    xact(0, 1, DM_H, 32'h12, 32'hFFFF1234, rd, err, lat, er, ee);
    xact(0, 0, DM_W, 32'h10, 32'h0, rd, err, lat, er, ee);
    checks++;
    if (rd !== 32'h123455EF) begin errors++; $display("FAIL sh_lane: got %h required 123455ef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat; bit [31:0] er; bit ee;
    bit        wr  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit [2:0]  ctl [4] = '{DM_W, DM_H, 3'b011, DM_BU};
    bit [31:0] ad  [4] = '{32'h12, 32'h11, 32'h10, 32'h10};
    for (int i = 0; i < 4; i++) begin
      xact(0, wr[i], ctl[i], ad[i], 32'h77777777, rd, err, lat, er, ee);
      checks++;
      if (err !== 1'b1 || rd !== 32'd0 || lat !== 2) begin
        errors++;
        $display("FAIL err_case%0d: got err=%b rd=%h lat=%0d required err=1 rd=0 lat=2", i, err, rd, lat);
      end
    end
    xact(0, 0, DM_W, 32'h10, 32'h0, rd, err, lat, er, ee);
    checks++;
    if (rd !== 32'h123455EF) begin errors++; $display("FAIL err_ram_kept: got %h required 123455ef", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic err; int lat; bit [31:0] er; bit ee;
    bit [31:0] a;
    for (int w = 0; w < 16; w++)
      xact(0, 1, DM_W, 32'h40 + 32'(4*w), $urandom, rd, err, lat, er, ee);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFFFC00) | (32'h40 + 32'($urandom_range(0, 63)));
      xact(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
           rd, err, lat, er, ee);
      checks++;
      if (rd !== er || err !== ee || lat !== 2) begin
        errors++;
        $display("FAIL random%0d: got rd=%h err=%b lat=%0d required rd=%h err=%b lat=2",
                 i, rd, err, lat, er, ee);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int lat; bit [31:0] er; bit ee;
    int busy_cnt;
    xact(1, 1, DM_W, 32'h10, 32'hCAFEF00D, rd, err, lat, er, ee);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wait_sw_latency: got %0d required 5", lat); end
    @(negedge clk);
    req[1] = 1'b1; dmwr[1] = 1'b0; dmctrl[1] = DM_W; addr[1] = 32'h10;
    @(posedge clk);
    #1 req[1] = 1'b0;
    busy_cnt = 0; lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy[1] === 1'b1) busy_cnt++;
      if (valid[1] === 1'b1) begin lat = k; break; end
      if (k == 2) begin
        req[1] = 1'b1; dmwr[1] = 1'b1; dmctrl[1] = DM_W; wdata[1] = 32'h0BADBAD0;
      end else begin
        req[1] = 1'b0; dmwr[1] = 1'b0;
      end
    end
    req[1] = 1'b0; dmwr[1] = 1'b0;
    $display("xact dut1 lw 10 rd=%h lat=%0d busy_cycles=%0d", datard[1], lat, busy_cnt);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wait_lw_latency: got %0d required 5", lat); end
    checks++;
    if (busy_cnt !== 4) begin errors++; $display("FAIL wait_busy_cycles: got %0d required 4", busy_cnt); end
    checks++;
    if (datard[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL wait_lw_data: got %h required cafef00d", datard[1]); end
    // Still in the RESP cycle: this request must be taken.
    req[1] = 1'b1; dmwr[1] = 1'b0; dmctrl[1] = DM_HU; addr[1] = 32'h12;
    @(posedge clk);
    #1 req[1] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid[1] === 1'b1) begin lat = k; break; end
    end
    $display("xact dut1 lhu 12 rd=%h lat=%0d", datard[1], lat);
    checks++;
    if (lat !== 5 || datard[1] !== 32'h0000CAFE) begin
      errors++;
      $display("FAIL resp_cycle_req: got lat=%0d rd=%h required lat=5 rd=0000cafe", lat, datard[1]);
    end
    model(1, 1'b0, DM_HU, 32'h12, 32'h0, ee, er);
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic err; int lat; bit [31:0] er; bit ee;
    xact(1, 1, DM_W, 32'h20, 32'h11112222, rd, err, lat, er, ee);
    @(negedge clk);
    req[1] = 1'b1; dmwr[1] = 1'b1; dmctrl[1] = DM_W; addr[1] = 32'h20; wdata[1] = 32'h99999999;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[1] !== 1'b1) begin errors++; $display("FAIL abort_in_flight: busy=%b required 1", busy[1]); end
    #2 rst[1] = 1'b1;
    #1;
    checks++;
    if ({busy[1], valid[1], merr[1]} !== 3'b000 || datard[1] !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b err=%b rd=%h required all zero",
               busy[1], valid[1], merr[1], datard[1]);
    end
    @(negedge clk);
    rst[1] = 1'b0;
    xact(1, 0, DM_W, 32'h20, 32'h0, rd, err, lat, er, ee);
    checks++;
    if (rd !== 32'h11112222 || lat !== 5) begin
      errors++;
      $display("FAIL abort_no_write: got rd=%h lat=%0d required 11112222 lat=5", rd, lat);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; addr[d] = '0; wdata[d] = '0; dmwr[d] = 1'b0; dmctrl[d] = '0;
      lr[d] = '0;
    end
    test_reset();
    test_word();
    test_sign();
    test_lanes();
    test_errors();
    test_random();
    test_wait_states();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Data-memory responder for the control unit's memory-side controls. It consumes DMWr and DMCtrl (a RISC-V funct3 width/sign code) plus an address and store data, and performs byte, half or word loads and stores on an internal word-organised RAM. Requests use a single-beat Req/Valid handshake, which lets both the multicycle and pipelined datapaths stall on it. The block sits between the execute-stage ALU result and the writeback mux, where it feeds RUDataWrSrc's memory input.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the RAM; must be a power of two.
WAIT_CYCLES, 0, extra wait-state cycles inserted before each access (0..15).

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
Req  input  1  request strobe; sampled only while Busy=0.
Address  input  32  byte address (the ALU result).
DataWr  input  32  store data; lanes are taken from its low bits.
DMWr  input  1  1 = store, 0 = load.
DMCtrl  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
Busy  output  1  1 while a request is in flight (states ACCESS and WAIT).
Valid  output  1  one-cycle response strobe.
DataRd  output  32  formatted load data; held until the next response.
MisalignErr  output  1  qualifies Valid; the request was misaligned or had an illegal DMCtrl.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, Busy=0, Valid=0, DataRd=0, MisalignErr=0, wait counter=0, captured request registers=0. RAM contents are not reset.
- Reset mid-operation aborts the request. No RAM write occurs unless the write edge has already passed.
- FSM states are IDLE, WAIT, ACCESS and RESP.
- IDLE or RESP with Req=1: capture Address, DataWr, DMWr and DMCtrl, load the counter with WAIT_CYCLES, then go to WAIT if WAIT_CYCLES>0, else ACCESS.
- RESP with Req=0 goes to IDLE.
- WAIT: decrement the counter each cycle and go to ACCESS when it reaches 1.
- ACCESS: perform the RAM read or write at the exiting edge, then go to RESP.
- RESP: Valid=1 for exactly one cycle. DataRd and MisalignErr update on the edge entering RESP.
- Latency: Req sampled at the end of cycle n gives Valid=1 in cycle n+2+WAIT_CYCLES. A Req in the RESP cycle is accepted, so back-to-back throughput is one request per 2+WAIT_CYCLES cycles.
- Req while Busy=1 is ignored, with no queuing.
- Word index is Address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias and wrap modulo 4*DEPTH_WORDS.
- Error condition, checked on the captured request: H/HU with Address[0]=1; W with Address[1:0]!=0; DMCtrl in {011,110,111}; and for stores, DMCtrl in {100,101} is also illegal.
- On an error: no RAM write, DataRd=0, MisalignErr=1 with Valid, and latency is unchanged.
- Store: read-modify-write of a single word using byte enables.
  - B: lane Address[1:0] gets DataWr[7:0].
  - H: lanes {Address[1],0} and {Address[1],1} get DataWr[15:0].
  - W: all four lanes are written.
  - DataRd keeps its previous value on a store response.
- Load: byte lane Address[1:0] or half lane Address[1]. B/H sign-extend to 32 bits; BU/HU zero-extend.
- Simultaneous reset and Req: reset wins.

Decomposition:
- dmem_pkg holds the DMCtrl localparams (DM_B, DM_H, DM_W, DM_BU, DM_HU) and the state enum type (IDLE, WAIT, ACCESS, RESP). The control unit imports the same DMCtrl constants.
- One combinational sub-module, dmem_load_format, takes the word, Address[1:0] and DMCtrl and produces the extended 32-bit value.
- Byte-enable generation stays inline in dmem_lsu.

Test Plan:
1. WAIT_CYCLES=0: SW 0xDEADBEEF at 0x10, then LW at 0x10 → Valid in cycle n+2, DataRd=0xDEADBEEF, MisalignErr=0.
2. Sign handling on word 0x10 = 0xDEADBEEF:
   - LB 0x13 → 0xFFFFFFDE.
   - LBU 0x13 → 0x000000DE.
   - LH 0x10 → 0xFFFFBEEF.
   - LHU 0x12 → 0x0000DEAD.
3. Byte lanes: SB 0x55 at 0x11, then LW 0x10 → 0xDEAD55EF. SH 0x1234 at 0x12 → word reads 0x123455EF.
4. Misaligned and illegal requests, each giving Valid with MisalignErr=1, DataRd=0 and the RAM unchanged:
   - LW at 0x12.
   - SH at 0x11.
   - DMCtrl=011.
   - Store with DMCtrl=100.
5. WAIT_CYCLES=3:
   - LW → Valid in cycle n+5, with Busy=1 for 4 cycles.
   - A Req during Busy is ignored.
   - A Req issued in the RESP cycle is accepted.
6. Assert rst during WAIT of an SW to 0x20 → all outputs return to their reset values asynchronously, and a later LW at 0x20 returns the old contents.
